// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the cache <-> main-memory arbitration path.
// Holds the arbiter state encoding, requester port ids and the default
// address/data widths that the instruction and data caches also use.
package riscv_mem_pkg;

  localparam int MEM_ADDR_W = 32;
  localparam int MEM_DATA_W = 32;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_GNT_I = 2'd1,
    ARB_GNT_D = 2'd2,
    ARB_RESP  = 2'd3
  } arb_state_t;

  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } port_t;

  // Watchdog counter width: enough to count to the timeout, kept within 8..32 bits.
  function automatic int wdog_width(input int timeout_cyc);
    int w;
    w = $clog2(timeout_cyc + 1);
    if (w < 8) w = 8;
    if (w > 32) w = 32;
    return w;
  endfunction

endpackage

// File: rtl/riscv_mem_arbiter.sv
// riscv_mem_arbiter: shares one main-memory port between the I-cache refill
// path and the D-cache path (load fill / write-through store), one transaction
// at a time, with a watchdog that aborts accesses memory never acknowledges.
// Ports:
//   clock, reset                      rising-edge clock, async active-high reset
//   i_req/i_addr -> i_done/i_rdata/i_err               instruction refill side
//   d_req/d_we/d_addr/d_wdata -> d_done/d_rdata/d_err  data side
//   mem_req/mem_we/mem_addr/mem_wdata -> mem_ack/mem_rdata   memory side
// Build option: define ARB_ROUND_ROBIN_EN to alternate grants on ties
// (otherwise the data side always wins a tie).
module riscv_mem_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int ADDR_W      = MEM_ADDR_W,
  parameter int DATA_W      = MEM_DATA_W,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clock,
  input  logic              reset,

  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_done,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_err,

  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_err,

  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = wdog_width(TIMEOUT_CYC);
  // The last GNT cycle is the one where the counter reads TIMEOUT_CYC-1,
  // so mem_req stays high for exactly TIMEOUT_CYC cycles.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  arb_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              i_done_q, i_done_d;
  logic              i_err_q, i_err_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic              d_done_q, d_done_d;
  logic              d_err_q, d_err_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

  logic              pick_d;
  logic              wdog_expired;

`ifdef ARB_ROUND_ROBIN_EN
  port_t             last_gnt_q, last_gnt_d;

  // On a tie, serve whichever side was not served last.
  assign pick_d = d_req && (!i_req || (last_gnt_q == PORT_I));
`else
  assign pick_d = d_req;
`endif

  assign wdog_expired = (TIMEOUT_CYC != 0) && (cnt_q == CNT_LAST);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    // Completion outputs are single-cycle pulses: low unless set below.
    i_done_d    = 1'b0;
    i_err_d     = 1'b0;
    i_rdata_d   = '0;
    d_done_d    = 1'b0;
    d_err_d     = 1'b0;
    d_rdata_d   = '0;
`ifdef ARB_ROUND_ROBIN_EN
    last_gnt_d  = last_gnt_q;
`endif

    case (state_q)
      ARB_IDLE: begin
        if (i_req || d_req) begin
          state_d     = pick_d ? ARB_GNT_D : ARB_GNT_I;
          cnt_d       = '0;
          mem_req_d   = 1'b1;
          mem_we_d    = pick_d && d_we;
          mem_addr_d  = pick_d ? d_addr : i_addr;
          mem_wdata_d = (pick_d && d_we) ? d_wdata : '0;
`ifdef ARB_ROUND_ROBIN_EN
          last_gnt_d  = pick_d ? PORT_D : PORT_I;
`endif
        end
      end

      ARB_GNT_I, ARB_GNT_D: begin
        // An ack arriving on the timeout cycle still counts as success.
        if (mem_ack) begin
          state_d   = ARB_RESP;
          mem_req_d = 1'b0;
          if (state_q == ARB_GNT_D) begin
            d_done_d  = 1'b1;
            d_rdata_d = mem_we_q ? '0 : mem_rdata;
          end else begin
            i_done_d  = 1'b1;
            i_rdata_d = mem_rdata;
          end
        end else if (wdog_expired) begin
          state_d   = ARB_RESP;
          mem_req_d = 1'b0;
          if (state_q == ARB_GNT_D) begin
            d_done_d = 1'b1;
            d_err_d  = 1'b1;
          end else begin
            i_done_d = 1'b1;
            i_err_d  = 1'b1;
          end
        end else if (TIMEOUT_CYC != 0) begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      // The done pulse is visible during this state; requests wait for IDLE.
      ARB_RESP: state_d = ARB_IDLE;

      default:  state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ARB_IDLE;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_done_q    <= 1'b0;
      i_err_q     <= 1'b0;
      i_rdata_q   <= '0;
      d_done_q    <= 1'b0;
      d_err_q     <= 1'b0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      i_done_q    <= i_done_d;
      i_err_q     <= i_err_d;
      i_rdata_q   <= i_rdata_d;
      d_done_q    <= d_done_d;
      d_err_q     <= d_err_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  // Starts as "I served last" so the data side wins the first tie.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_gnt_q <= PORT_I;
    end else begin
      last_gnt_q <= last_gnt_d;
    end
  end
`endif

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign i_done    = i_done_q;
  assign i_err     = i_err_q;
  assign i_rdata   = i_rdata_q;
  assign d_done    = d_done_q;
  assign d_err     = d_err_q;
  assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Bench for riscv_mem_arbiter: per-port requester agents, a memory responder
// that checks each memory request against an expected-order queue, and a
// response monitor that pops per-port expected completions.
module tb_riscv_mem_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        i_req, i_done, i_err;
  logic [31:0] i_addr, i_rdata;
  logic        d_req, d_we, d_done, d_err;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        mem_req, mem_we, mem_ack, mem_ack_m, spur_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  assign mem_ack = mem_ack_m | spur_ack;

  always #5 clock = ~clock;

  riscv_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(4)) dut (
    .clock(clock), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done), .d_rdata(d_rdata), .d_err(d_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  typedef struct {logic we; logic [31:0] addr; logic [31:0] wdata;} job_t;
  typedef struct {logic [31:0] rdata; logic err;} rsp_t;
  typedef struct {logic we; logic [31:0] addr; logic [31:0] wdata; logic [31:0] rdata; int delay;} mem_t;

  job_t i_jobs[$], d_jobs[$];
  rsp_t exp_i[$], exp_d[$];
  mem_t mem_q[$];

  int n_cmp = 0, n_bad = 0;
  int cyc = 0;
  int i_req_cyc, mem_rise_cyc, ack_cyc, i_done_cyc, last_hi;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- requester agents ----------------
  initial begin : i_agent
    logic seen;
    bit   busy;
    job_t j;
    i_req = 1'b0; i_addr = '0; busy = 0;
    forever begin
      @(negedge clock); seen = i_done;
      @(posedge clock); #1;
      if (reset) begin
        busy = 0; i_req = 1'b0;
      end else begin
        if (busy && seen) begin busy = 0; i_req = 1'b0; end
        if (!busy && i_jobs.size() > 0) begin
          j = i_jobs.pop_front();
          i_addr = j.addr; i_req = 1'b1; busy = 1; i_req_cyc = cyc;
        end
      end
    end
  end

  initial begin : d_agent
    logic seen;
    bit   busy;
    job_t j;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; busy = 0;
    forever begin
      @(negedge clock); seen = d_done;
      @(posedge clock); #1;
      if (reset) begin
        busy = 0; d_req = 1'b0;
      end else begin
        if (busy && seen) begin busy = 0; d_req = 1'b0; end
        if (!busy && d_jobs.size() > 0) begin
          j = d_jobs.pop_front();
          d_we = j.we; d_addr = j.addr; d_wdata = j.wdata; d_req = 1'b1; busy = 1;
        end
      end
    end
  end

  // ---------------- memory responder / request checker ----------------
  initial begin : mem_model
    mem_t m;
    int   k, hi;
    bit   acked;
    mem_ack_m = 1'b0; mem_rdata = '0;
    forever begin
      @(negedge clock);
      if (mem_req && !reset) begin
        mem_rise_cyc = cyc;
        if (mem_q.size() == 0) begin
          chk32("mem_req_unexpected", 32'(mem_req), 32'd0);
          m = '{we: 1'b0, addr: 32'd0, wdata: 32'd0, rdata: 32'd0, delay: -1};
        end else begin
          m = mem_q.pop_front();
          chk32("mem_we", 32'(mem_we), 32'(m.we));
          chk32("mem_addr", mem_addr, m.addr);
          if (m.we) chk32("mem_wdata", mem_wdata, m.wdata);
        end
        hi = 1; k = 0; acked = 0;
        while (!acked) begin
          @(posedge clock); #1; k++;
          if (!mem_req || reset) break;
          hi++;
          chk32("mem_addr_hold", mem_addr, m.addr);
          if (m.we) chk32("mem_wdata_hold", mem_wdata, m.wdata);
          if (m.delay == k) begin
            mem_ack_m = 1'b1; mem_rdata = m.rdata; ack_cyc = cyc;
            @(posedge clock); #1;
            mem_ack_m = 1'b0; mem_rdata = '0; acked = 1;
            chk32("mem_req_drop_on_ack", 32'(mem_req), 32'd0);
          end
        end
        last_hi = hi;
      end
    end
  end

  // ---------------- completion monitor ----------------
  initial begin : rsp_mon
    rsp_t e;
    forever begin
      @(negedge clock);
      if (!reset) begin
        if (i_done) begin
          i_done_cyc = cyc;
          if (exp_i.size() == 0) chk32("i_done_unexpected", 32'(i_done), 32'd0);
          else begin
            e = exp_i.pop_front();
            chk32("i_rdata", i_rdata, e.rdata);
            chk32("i_err", 32'(i_err), 32'(e.err));
          end
        end else if (i_err) chk32("i_err_without_done", 32'(i_err), 32'd0);
        if (d_done) begin
          if (exp_d.size() == 0) chk32("d_done_unexpected", 32'(d_done), 32'd0);
          else begin
            e = exp_d.pop_front();
            chk32("d_rdata", d_rdata, e.rdata);
            chk32("d_err", 32'(d_err), 32'(e.err));
          end
        end else if (d_err) chk32("d_err_without_done", 32'(d_err), 32'd0);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc_wait(input int n);
    repeat (n) begin @(posedge clock); #3; end
  endtask

  task automatic mem_expect(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] rdata, input int delay);
    mem_q.push_back('{we: we, addr: addr, wdata: wdata, rdata: rdata, delay: delay});
  endtask

  task automatic issue_i(input logic [31:0] addr, input logic [31:0] exp_rdata, input logic exp_err);
    i_jobs.push_back('{we: 1'b0, addr: addr, wdata: 32'd0});
    exp_i.push_back('{rdata: exp_rdata, err: exp_err});
  endtask

  task automatic issue_d(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata, input logic exp_err);
    d_jobs.push_back('{we: we, addr: addr, wdata: wdata});
    exp_d.push_back('{rdata: exp_rdata, err: exp_err});
  endtask

  task automatic drain(input string name);
    int t;
    int pend;
    t = 0;
    pend = exp_i.size() + exp_d.size() + mem_q.size() + i_jobs.size() + d_jobs.size();
    while (pend != 0 && t < 60) begin
      cyc_wait(1); t++;
      pend = exp_i.size() + exp_d.size() + mem_q.size() + i_jobs.size() + d_jobs.size();
    end
    chk32({name, "_drain_pending"}, pend, 32'd0);
    if (pend != 0) begin
      exp_i.delete(); exp_d.delete(); mem_q.delete(); i_jobs.delete(); d_jobs.delete();
    end
    cyc_wait(3);
  endtask

  task automatic chk_all_zero(input string name);
    chk32({name, "_ctrl"}, 32'({mem_req, mem_we, i_done, i_err, d_done, d_err}), 32'd0);
    chk32({name, "_mem_addr"}, mem_addr, 32'd0);
    chk32({name, "_mem_wdata"}, mem_wdata, 32'd0);
    chk32({name, "_i_rdata"}, i_rdata, 32'd0);
    chk32({name, "_d_rdata"}, d_rdata, 32'd0);
  endtask

  initial begin : global_guard
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  // ---------------- directed sequence ----------------
  initial begin : main
    int t;
    reset = 1'b1; spur_ack = 1'b0;
    cyc_wait(2);
    chk_all_zero("reset");
    reset = 1'b0;
    cyc_wait(2);

    // Write-through store: wdata held until ack, d_rdata forced to 0.
    mem_expect(1'b1, 32'h10, 32'hDEADBEEF, 32'hA5A5A5A5, 1);
    issue_d(1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
    drain("store");

    // Instruction refill, ack two cycles after mem_req.
    mem_expect(1'b0, 32'h40, 32'h0, 32'h00500093, 2);
    issue_i(32'h40, 32'h00500093, 1'b0);
    drain("ifetch");
    chk32("ifetch_req_to_memreq", mem_rise_cyc, i_req_cyc + 1);
    chk32("ifetch_ack_to_done", i_done_cyc, ack_cyc + 1);
    chk32("ifetch_memreq_cycles", last_hi, 32'd3);

    // Simultaneous requests, each side one job: D first, then I.
    mem_expect(1'b0, 32'h20, 32'h0, 32'h11111111, 1);
    mem_expect(1'b0, 32'h44, 32'h0, 32'h22222222, 1);
    issue_d(1'b0, 32'h20, 32'h0, 32'h11111111, 1'b0);
    issue_i(32'h44, 32'h22222222, 1'b0);
    drain("tie_a");

    // Simultaneous requests, each side two jobs held back-to-back.
`ifdef ARB_ROUND_ROBIN_EN
    mem_expect(1'b0, 32'h24, 32'h0, 32'h33333333, 1);
    mem_expect(1'b0, 32'h48, 32'h0, 32'h55555555, 1);
    mem_expect(1'b0, 32'h28, 32'h0, 32'h44444444, 1);
    mem_expect(1'b0, 32'h4C, 32'h0, 32'h66666666, 1);
`else
    mem_expect(1'b0, 32'h24, 32'h0, 32'h33333333, 1);
    mem_expect(1'b0, 32'h28, 32'h0, 32'h44444444, 1);
    mem_expect(1'b0, 32'h48, 32'h0, 32'h55555555, 1);
    mem_expect(1'b0, 32'h4C, 32'h0, 32'h66666666, 1);
`endif
    issue_d(1'b0, 32'h24, 32'h0, 32'h33333333, 1'b0);
    issue_d(1'b0, 32'h28, 32'h0, 32'h44444444, 1'b0);
    issue_i(32'h48, 32'h55555555, 1'b0);
    issue_i(32'h4C, 32'h66666666, 1'b0);
    drain("tie_b");

    // Ack arrives on the final watchdog cycle: ack wins, no error.
    mem_expect(1'b0, 32'h30, 32'h0, 32'h77777777, 3);
    issue_d(1'b0, 32'h30, 32'h0, 32'h77777777, 1'b0);
    drain("ack_at_timeout");
    chk32("ack_at_timeout_memreq_cycles", last_hi, 32'd4);

    // Memory never acks: mem_req for 4 cycles, then done+err with rdata 0.
    mem_expect(1'b0, 32'h34, 32'h0, 32'h0, -1);
    issue_d(1'b0, 32'h34, 32'h0, 32'h0, 1'b1);
    drain("timeout");
    chk32("timeout_memreq_cycles", last_hi, 32'd4);

    // Spurious ack while idle: nothing happens.
    spur_ack = 1'b1;
    cyc_wait(1);
    spur_ack = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk32("spurious_ack_no_memreq", 32'(mem_req), 32'd0);
      chk32("spurious_ack_no_done", 32'({i_done, d_done}), 32'd0);
      cyc_wait(1);
    end

    // Reset during GNT_I with mem_req high, then a normal data load.
    mem_expect(1'b0, 32'h50, 32'h0, 32'h88888888, 10);
    issue_i(32'h50, 32'h88888888, 1'b0);
    t = 0;
    while (!mem_req && t < 10) begin cyc_wait(1); t++; end
    cyc_wait(1);
    chk32("rst_mid_memreq_before", 32'(mem_req), 32'd1);
    reset = 1'b1;
    #1;
    chk_all_zero("rst_mid");
    exp_i.delete();
    cyc_wait(2);
    reset = 1'b0;
    cyc_wait(1);
    mem_expect(1'b0, 32'h60, 32'h0, 32'h99999999, 1);
    issue_d(1'b0, 32'h60, 32'h0, 32'h99999999, 1'b0);
    drain("after_reset");

    cyc_wait(3);
    chk32("final_mem_queue_empty", mem_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
